// File: rtl/hazard_scheduler_pkg.sv
// Shared definitions for the decode-stage issue controller: register-file
// geometry, flush FSM state encoding and a helper that filters out x0.
package hazard_scheduler_pkg;

    localparam int REG_IDX_W = 5;
    localparam int NUM_REGS  = 32;
    localparam logic [REG_IDX_W-1:0] REG_X0 = 5'd0;

    typedef enum logic [0:0] {
        FLUSH_IDLE   = 1'b0,
        FLUSH_ACTIVE = 1'b1
    } flushState_t;

    // x0 is hardwired to zero, so it never carries a pending write
    function automatic logic isTracked(input logic [REG_IDX_W-1:0] idx);
        return idx != REG_X0;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Per-register pending-write counters. One increment port (issue) and one
// decrement port (writeback); lookups report busy sources and a saturated rd.
module hazard_scoreboard
    import hazard_scheduler_pkg::*;
#(
    parameter int CNT_W = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 incEn_i,
    input  logic [REG_IDX_W-1:0] incRd_i,
    input  logic                 decEn_i,
    input  logic [REG_IDX_W-1:0] decRd_i,
    input  logic [REG_IDX_W-1:0] rs1_i,
    input  logic [REG_IDX_W-1:0] rs2_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    output logic                 rs1Busy_o,
    output logic                 rs2Busy_o,
    output logic                 rdFull_o,
    output logic                 decEmpty_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Entry 0 exists only to keep indexing simple; it is never written.
    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];

    // Lookups read registered counts only, so a same-cycle writeback
    // cannot release a hazard (no bypass, one-cycle penalty).
    always_comb begin
        rs1Busy_o  = isTracked(rs1_i) && (cnt_q[rs1_i] != '0);
        rs2Busy_o  = isTracked(rs2_i) && (cnt_q[rs2_i] != '0);
        rdFull_o   = isTracked(rd_i)  && (cnt_q[rd_i] == CNT_MAX);
        decEmpty_o = (cnt_q[decRd_i] == '0);
    end

    // Net update per register: an issue and a writeback to the same rd
    // cancel; a decrement of an empty counter is dropped.
    always_comb begin
        cnt_d = cnt_q;
        for (int r = 1; r < NUM_REGS; r++) begin
            if ((incEn_i && (incRd_i == REG_IDX_W'(r))) &&
                !(decEn_i && (decRd_i == REG_IDX_W'(r)) && (cnt_q[r] != '0))) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (!(incEn_i && (incRd_i == REG_IDX_W'(r))) &&
                         (decEn_i && (decRd_i == REG_IDX_W'(r)) && (cnt_q[r] != '0))) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    // Counter storage with synchronous clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q <= '{default: '0};
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/hazard_scheduler.sv
// Decode-stage issue controller: stalls on RAW/WAW hazards or a full
// in-flight window, flushes decode after a redirect, counts stall cycles.
module hazard_scheduler
    import hazard_scheduler_pkg::*;
#(
    parameter int CNT_W        = 2,
    parameter int MAX_INFLIGHT = 4,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MEM_WAIT,
    input  logic        DEC_VALID,
    input  logic [4:0]  DEC_RS1,
    input  logic [4:0]  DEC_RS2,
    input  logic [4:0]  DEC_RD,
    input  logic        DEC_USE_RS1,
    input  logic        DEC_USE_RS2,
    input  logic        DEC_WR_RD,
    input  logic        WB_VALID,
    input  logic [4:0]  WB_RD,
    input  logic        WB_WR,
    input  logic        REDIRECT,
    output logic        STALL,
    output logic        ISSUE,
    output logic        FLUSH,
    output logic [3:0]  INFLIGHT,
    output logic [31:0] PERF_STALLS
);

    localparam logic [3:0] MAX_INFL     = 4'(MAX_INFLIGHT);
    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    flushState_t flushState_q, flushState_d;
    logic [2:0]  flushCnt_q, flushCnt_d;
    logic [3:0]  inflight_q, inflight_d;
    logic [31:0] perfStalls_q, perfStalls_d;

    logic rs1Busy, rs2Busy, rdFull, wbCntEmpty;
    logic hazard, flushNow, wbRetire;
    logic sbInc, sbDec;

    assign sbInc = ISSUE && DEC_WR_RD && isTracked(DEC_RD);
    assign sbDec = WB_VALID && WB_WR && isTracked(WB_RD);

    hazard_scoreboard #(
        .CNT_W (CNT_W)
    ) uScoreboard (
        .CLK        (CLK),
        .RST        (RST),
        .incEn_i    (sbInc),
        .incRd_i    (DEC_RD),
        .decEn_i    (sbDec),
        .decRd_i    (WB_RD),
        .rs1_i      (DEC_RS1),
        .rs2_i      (DEC_RS2),
        .rd_i       (DEC_RD),
        .rs1Busy_o  (rs1Busy),
        .rs2Busy_o  (rs2Busy),
        .rdFull_o   (rdFull),
        .decEmpty_o (wbCntEmpty)
    );

    // Hazard detection from registered state, then issue/stall gating where
    // flush wins over hazard and MEM_WAIT suppresses both.
    always_comb begin
        hazard = DEC_VALID && ((DEC_USE_RS1 && rs1Busy) ||
                               (DEC_USE_RS2 && rs2Busy) ||
                               (DEC_WR_RD   && rdFull)  ||
                               (inflight_q == MAX_INFL));
        STALL  = hazard && !flushNow && !MEM_WAIT;
        ISSUE  = DEC_VALID && !hazard && !flushNow && !MEM_WAIT;
    end

    // Flush FSM next state: FLUSH is raised combinationally in the redirect
    // cycle, then held while the down-counter is nonzero; MEM_WAIT freezes it.
    always_comb begin
        flushState_d = flushState_q;
        flushCnt_d   = flushCnt_q;
        flushNow     = 1'b0;
        case (flushState_q)
            FLUSH_IDLE: begin
                if (REDIRECT) begin
                    flushNow = 1'b1;
                    if (!MEM_WAIT && (FLUSH_RELOAD != 3'd0)) begin
                        flushState_d = FLUSH_ACTIVE;
                        flushCnt_d   = FLUSH_RELOAD;
                    end
                end
            end
            FLUSH_ACTIVE: begin
                flushNow = 1'b1;
                if (!MEM_WAIT) begin
                    if (REDIRECT) begin
                        flushCnt_d = FLUSH_RELOAD;
                    end else begin
                        flushCnt_d = flushCnt_q - 3'd1;
                        if (flushCnt_q == 3'd1) begin
                            flushState_d = FLUSH_IDLE;
                        end
                    end
                end
            end
            default: begin
                flushState_d = FLUSH_IDLE;
                flushCnt_d   = 3'd0;
            end
        endcase
    end

    assign FLUSH = flushNow;

    // In-flight window and saturating stall counter; a writeback with an
    // empty window is dropped rather than wrapping.
    always_comb begin
        wbRetire     = WB_VALID && (inflight_q != 4'd0);
        inflight_d   = inflight_q + 4'(ISSUE) - 4'(wbRetire);
        perfStalls_d = (STALL && (perfStalls_q != 32'hFFFF_FFFF)) ?
                       perfStalls_q + 32'd1 : perfStalls_q;
    end

    // State registers for the flush FSM, in-flight count and perf counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            flushState_q <= FLUSH_IDLE;
            flushCnt_q   <= 3'd0;
            inflight_q   <= 4'd0;
            perfStalls_q <= 32'd0;
        end else begin
            flushState_q <= flushState_d;
            flushCnt_q   <= flushCnt_d;
            inflight_q   <= inflight_d;
            perfStalls_q <= perfStalls_d;
        end
    end

    assign INFLIGHT    = inflight_q;
    assign PERF_STALLS = perfStalls_q;

    // Completions must correspond to something issued and must not arrive
    // while the pipeline is frozen.
    wbNoInflightUnderflow: assert property (@(posedge CLK) disable iff (RST)
        WB_VALID |-> (inflight_q != 4'd0));
    wbNoCountUnderflow: assert property (@(posedge CLK) disable iff (RST)
        (WB_VALID && WB_WR && isTracked(WB_RD)) |-> !wbCntEmpty);
    wbNotUnderMemWait: assert property (@(posedge CLK) disable iff (RST)
        MEM_WAIT |-> !WB_VALID);

endmodule

// File: tb/tb_hazard_scheduler.sv
// Directed bench for hazard_scheduler: a register-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_hazard_scheduler;

    localparam int CNT_W        = 2;
    localparam int MAX_INFLIGHT = 4;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MEM_WAIT, DEC_VALID, DEC_USE_RS1, DEC_USE_RS2, DEC_WR_RD;
    logic [4:0]  DEC_RS1, DEC_RS2, DEC_RD, WB_RD;
    logic        WB_VALID, WB_WR, REDIRECT;
    logic        STALL, ISSUE, FLUSH;
    logic [3:0]  INFLIGHT;
    logic [31:0] PERF_STALLS;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int          mCnt [32];
    int          mInfl;
    int          mFlushRemain;
    logic [31:0] mPerf;

    hazard_scheduler #(
        .CNT_W        (CNT_W),
        .MAX_INFLIGHT (MAX_INFLIGHT),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .CLK         (CLK),
        .RST         (RST),
        .MEM_WAIT    (MEM_WAIT),
        .DEC_VALID   (DEC_VALID),
        .DEC_RS1     (DEC_RS1),
        .DEC_RS2     (DEC_RS2),
        .DEC_RD      (DEC_RD),
        .DEC_USE_RS1 (DEC_USE_RS1),
        .DEC_USE_RS2 (DEC_USE_RS2),
        .DEC_WR_RD   (DEC_WR_RD),
        .WB_VALID    (WB_VALID),
        .WB_RD       (WB_RD),
        .WB_WR       (WB_WR),
        .REDIRECT    (REDIRECT),
        .STALL       (STALL),
        .ISSUE       (ISSUE),
        .FLUSH       (FLUSH),
        .INFLIGHT    (INFLIGHT),
        .PERF_STALLS (PERF_STALLS)
    );

    always #5 CLK = ~CLK;

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge
    task automatic applyStimulus(
        input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic u1, input logic u2, input logic wr,
        input logic wbv, input logic [4:0] wbRd, input logic wbWr,
        input logic redir, input logic mw);
        @(posedge CLK);
        #1;
        DEC_VALID = v;   DEC_RS1 = rs1;  DEC_RS2 = rs2;  DEC_RD = rd;
        DEC_USE_RS1 = u1; DEC_USE_RS2 = u2; DEC_WR_RD = wr;
        WB_VALID = wbv;  WB_RD = wbRd;   WB_WR = wbWr;
        REDIRECT = redir; MEM_WAIT = mw;
    endtask

    // Hand-computed expectation for the current cycle, sampled mid-cycle
    task automatic checkOutput(input string tag, input logic eStall, input logic eIssue,
                               input logic eFlush, input logic [3:0] eInfl);
        @(negedge CLK);
        checkVal({tag, " STALL"},    32'(STALL),    32'(eStall));
        checkVal({tag, " ISSUE"},    32'(ISSUE),    32'(eIssue));
        checkVal({tag, " FLUSH"},    32'(FLUSH),    32'(eFlush));
        checkVal({tag, " INFLIGHT"}, 32'(INFLIGHT), 32'(eInfl));
    endtask

    task automatic checkPerf(input string tag, input logic [31:0] ePerf);
        checkVal({tag, " PERF_STALLS"}, PERF_STALLS, ePerf);
    endtask

    // Reference model: evaluates the issue rules on each falling edge, compares,
    // then advances its own state to what the next rising edge should produce.
    initial begin
        bit expHaz, expFlush, expStall, expIssue, wbInflOk, wbCntOk;
        forever begin
            @(negedge CLK);
            if (RST) begin
                foreach (mCnt[i]) mCnt[i] = 0;
                mInfl = 0;
                mFlushRemain = 0;
                mPerf = 32'd0;
            end else begin
                expFlush = REDIRECT || (mFlushRemain > 0);
                expHaz = DEC_VALID && (
                    (DEC_USE_RS1 && DEC_RS1 != 0 && mCnt[DEC_RS1] != 0) ||
                    (DEC_USE_RS2 && DEC_RS2 != 0 && mCnt[DEC_RS2] != 0) ||
                    (DEC_WR_RD && DEC_RD != 0 && mCnt[DEC_RD] == CNT_MAX) ||
                    (mInfl == MAX_INFLIGHT));
                expStall = expHaz && !expFlush && !MEM_WAIT;
                expIssue = DEC_VALID && !expHaz && !expFlush && !MEM_WAIT;

                checkVal("model STALL",       32'(STALL),    32'(expStall));
                checkVal("model ISSUE",       32'(ISSUE),    32'(expIssue));
                checkVal("model FLUSH",       32'(FLUSH),    32'(expFlush));
                checkVal("model INFLIGHT",    32'(INFLIGHT), 32'(mInfl));
                checkVal("model PERF_STALLS", PERF_STALLS,   mPerf);

                if (!MEM_WAIT) begin
                    if (REDIRECT) mFlushRemain = FLUSH_CYCLES - 1;
                    else if (mFlushRemain > 0) mFlushRemain--;
                end
                wbInflOk = WB_VALID && (mInfl > 0);
                wbCntOk  = WB_VALID && WB_WR && (WB_RD != 0) && (mCnt[WB_RD] > 0);
                if (expIssue) begin
                    mInfl++;
                    if (DEC_WR_RD && DEC_RD != 0) mCnt[DEC_RD]++;
                end
                if (wbInflOk) mInfl--;
                if (wbCntOk) mCnt[WB_RD]--;
                if (expStall && mPerf != 32'hFFFF_FFFF) mPerf = mPerf + 32'd1;
            end
        end
    end

    // Guard against a stuck run
    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL timeout: got running expected finished");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

    // Directed scenarios
    initial begin
        RST = 1'b1;
        DEC_VALID = 0; DEC_RS1 = 0; DEC_RS2 = 0; DEC_RD = 0;
        DEC_USE_RS1 = 0; DEC_USE_RS2 = 0; DEC_WR_RD = 0;
        WB_VALID = 0; WB_RD = 0; WB_WR = 0; REDIRECT = 0; MEM_WAIT = 0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        checkOutput("reset", 0, 0, 0, 0);
        checkPerf("reset", 32'd0);

        // RAW on x5: writer issues, reader stalls until a cycle after WB
        applyStimulus(1, 5'd1, 5'd0, 5'd5, 1, 0, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t1 addi issue", 0, 1, 0, 1'b0);
        applyStimulus(1, 5'd5, 5'd2, 5'd6, 1, 1, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t1 raw stall", 1, 0, 0, 1);
        applyStimulus(1, 5'd5, 5'd2, 5'd6, 1, 1, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t1 raw stall2", 1, 0, 0, 1);
        checkPerf("t1 mid", 32'd1);
        applyStimulus(1, 5'd5, 5'd2, 5'd6, 1, 1, 1, 1, 5'd5, 1, 0, 0);
        checkOutput("t1 wb no bypass", 1, 0, 0, 1);
        applyStimulus(1, 5'd5, 5'd2, 5'd6, 1, 1, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t1 issue after wb", 0, 1, 0, 0);
        checkPerf("t1 end", 32'd3);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd6, 1, 0, 0);
        checkOutput("t1 drain", 0, 0, 0, 1);

        // In-flight limit with independent ops
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
            checkOutput("t2 fill", 0, 1, 0, 4'(i));
        end
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        checkOutput("t2 window full", 1, 0, 0, 4);
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 0);
        checkOutput("t2 wb cycle", 1, 0, 0, 4);
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        checkOutput("t2 fifth issues", 0, 1, 0, 3);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 0, 0, 0);
            checkOutput("t2 drain", 0, 0, 0, 4'(4 - i));
        end
        checkPerf("t2 end", 32'd5);

        // WAW saturation on x7 and net-zero issue+WB
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 5'd0, 0, 0, 0);
            checkOutput("t3 waw issue", 0, 1, 0, 4'(i));
        end
        applyStimulus(1, 5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t3 cnt full", 1, 0, 0, 3);
        applyStimulus(1, 5'd0, 5'd0, 5'd7, 0, 0, 1, 1, 5'd7, 1, 0, 0);
        checkOutput("t3 wb while full", 1, 0, 0, 3);
        applyStimulus(1, 5'd0, 5'd0, 5'd7, 0, 0, 1, 1, 5'd7, 1, 0, 0);
        checkOutput("t3 issue plus wb", 0, 1, 0, 2);
        applyStimulus(1, 5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t3 refill", 0, 1, 0, 2);
        applyStimulus(1, 5'd0, 5'd0, 5'd7, 0, 0, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t3 full again", 1, 0, 0, 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd7, 1, 0, 0);
            checkOutput("t3 drain", 0, 0, 0, 4'(3 - i));
        end
        checkPerf("t3 end", 32'd8);

        // Redirect flush, extension by a second redirect, priority over hazard
        applyStimulus(1, 5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 5'd0, 0, 1, 0);
        checkOutput("t4 redirect", 0, 0, 1, 0);
        applyStimulus(1, 5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t4 flush hold", 0, 0, 1, 0);
        applyStimulus(1, 5'd0, 5'd0, 5'd9, 0, 0, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t4 flush done", 0, 1, 0, 0);
        applyStimulus(1, 5'd9, 5'd0, 5'd10, 1, 0, 0, 0, 5'd0, 0, 1, 0);
        checkOutput("t4 redirect2", 0, 0, 1, 1);
        applyStimulus(1, 5'd9, 5'd0, 5'd10, 1, 0, 0, 0, 5'd0, 0, 1, 0);
        checkOutput("t4 reload", 0, 0, 1, 1);
        applyStimulus(1, 5'd9, 5'd0, 5'd10, 1, 0, 0, 0, 5'd0, 0, 0, 0);
        checkOutput("t4 extended", 0, 0, 1, 1);
        applyStimulus(1, 5'd9, 5'd0, 5'd10, 1, 0, 0, 0, 5'd0, 0, 0, 0);
        checkOutput("t4 hazard visible", 1, 0, 0, 1);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd9, 1, 0, 0);
        checkOutput("t4 drain", 0, 0, 0, 1);
        checkPerf("t4 end", 32'd9);

        // x0 reads/writes never hazard or count
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 5'd0, 0, 0, 0);
            checkOutput("t5 x0 issue", 0, 1, 0, 4'(i));
        end
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t5 window only", 1, 0, 0, 4);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 1, 0, 0);
            checkOutput("t5 drain", 0, 0, 0, 4'(4 - i));
        end
        applyStimulus(1, 5'd0, 5'd0, 5'd0, 1, 1, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t5 x0 after", 0, 1, 0, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 5'd0, 1, 0, 0);
        checkOutput("t5 final", 0, 0, 0, 1);
        checkPerf("t5 end", 32'd10);

        // MEM_WAIT freeze during hazard and flush, then reset mid-stream
        applyStimulus(1, 5'd0, 5'd0, 5'd3, 0, 0, 1, 0, 5'd0, 0, 0, 0);
        checkOutput("t6 writer", 0, 1, 0, 0);
        applyStimulus(1, 5'd3, 5'd0, 5'd11, 1, 0, 0, 0, 5'd0, 0, 0, 1);
        checkOutput("t6 memwait hazard", 0, 0, 0, 1);
        applyStimulus(1, 5'd3, 5'd0, 5'd11, 1, 0, 0, 0, 5'd0, 0, 0, 0);
        checkOutput("t6 stall", 1, 0, 0, 1);
        applyStimulus(1, 5'd3, 5'd0, 5'd11, 1, 0, 0, 0, 5'd0, 0, 1, 0);
        checkOutput("t6 redirect", 0, 0, 1, 1);
        applyStimulus(1, 5'd3, 5'd0, 5'd11, 1, 0, 0, 0, 5'd0, 0, 0, 1);
        checkOutput("t6 frozen1", 0, 0, 1, 1);
        applyStimulus(1, 5'd3, 5'd0, 5'd11, 1, 0, 0, 0, 5'd0, 0, 0, 1);
        checkOutput("t6 frozen2", 0, 0, 1, 1);
        applyStimulus(1, 5'd3, 5'd0, 5'd11, 1, 0, 0, 0, 5'd0, 0, 0, 0);
        checkOutput("t6 thaw", 0, 0, 1, 1);
        applyStimulus(1, 5'd3, 5'd0, 5'd11, 1, 0, 0, 0, 5'd0, 0, 1, 0);
        checkOutput("t6 redirect again", 0, 0, 1, 1);
        checkPerf("t6 before reset", 32'd11);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        checkOutput("t6 post reset", 0, 0, 0, 0);
        checkPerf("t6 post reset", 32'd0);
        applyStimulus(1, 5'd3, 5'd0, 5'd11, 1, 0, 0, 0, 5'd0, 0, 0, 0);
        checkOutput("t6 scoreboard cleared", 0, 1, 0, 0);
        applyStimulus(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 5'd0, 0, 0, 0);
        checkOutput("t6 end", 0, 0, 0, 1);

        @(posedge CLK);
        @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
